// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg                                                             |
// | Widths and packer state encoding shared by the FIFO read packer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fifo_pkg;

   localparam int WORD_W = 16;
   localparam int BEAT_W = 32;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_HALF  = 2'd1,
      S_BEAT  = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_rd_packer                                                       |
// | Reads 16-bit words from a FIFO and packs pairs into 32-bit beats.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter logic [WORD_W-1:0] PAD_WORD = 16'h0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   input  logic [WORD_W-1:0] fifo_data,
   input  logic              fifo_underflow,
   output logic              fifo_rd_en,
   input  logic              flush,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [BEAT_W-1:0] m_data,
   output logic              m_partial,
   output logic [15:0]       beat_count,
   output logic              err_underflow
);

   logic              rd_pend_q,       rd_pend_d;
   logic              lo_valid_q,      lo_valid_d;
   logic [WORD_W-1:0] lo_q,            lo_d;
   logic              beat_pend_q,     beat_pend_d;
   logic [BEAT_W-1:0] beat_q,          beat_d;
   logic              m_valid_q,       m_valid_d;
   logic [BEAT_W-1:0] m_data_q,        m_data_d;
   logic              m_partial_q,     m_partial_d;
   logic [15:0]       beat_count_q,    beat_count_d;
   logic              err_underflow_q, err_underflow_d;

   logic [2:0]        w_occ;
   logic              w_out_free;
   logic              w_flush_fire;
   state_e            state;

   // Words in flight or held, counting a pending beat as two; caps reads so
   // nothing returned by the FIFO ever has to be dropped.
   assign w_occ = {1'b0, beat_pend_q, 1'b0} + {2'b00, lo_valid_q} + {2'b00, rd_pend_q};
   assign fifo_rd_en = !fifo_empty && (w_occ < 3'd2) && !rst;

   assign w_out_free   = !m_valid_q || m_ready;
   assign w_flush_fire = flush && lo_valid_q && !rd_pend_q && !beat_pend_q
                         && fifo_empty && w_out_free;

   always_comb begin
      state = S_EMPTY;
      if (beat_pend_q) begin
         state = S_BEAT;
      end else if (lo_valid_q) begin
         state = S_HALF;
      end
   end

   always_comb begin
      rd_pend_d       = fifo_rd_en;
      lo_valid_d      = lo_valid_q;
      lo_d            = lo_q;
      beat_pend_d     = beat_pend_q;
      beat_d          = beat_q;
      m_valid_d       = m_valid_q;
      m_data_d        = m_data_q;
      m_partial_d     = m_partial_q;
      beat_count_d    = beat_count_q;
      err_underflow_d = err_underflow_q | fifo_underflow;

      if (m_valid_q && m_ready) begin
         m_valid_d    = 1'b0;
         beat_count_d = beat_count_q + 16'd1;
      end

      if (beat_pend_q && w_out_free) begin
         m_data_d    = beat_q;
         m_partial_d = 1'b0;
         m_valid_d   = 1'b1;
         beat_pend_d = 1'b0;
      end

      if (rd_pend_q) begin
         if (!lo_valid_q) begin
            lo_d       = fifo_data;
            lo_valid_d = 1'b1;
         end else begin
            lo_valid_d = 1'b0;
            if (w_out_free && !beat_pend_q) begin
               m_data_d    = {fifo_data, lo_q};
               m_partial_d = 1'b0;
               m_valid_d   = 1'b1;
            end else begin
               beat_d      = {fifo_data, lo_q};
               beat_pend_d = 1'b1;
            end
         end
      end else if (w_flush_fire) begin
         m_data_d    = {PAD_WORD, lo_q};
         m_partial_d = 1'b1;
         m_valid_d   = 1'b1;
         lo_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pend_q       <= 1'b0;
         lo_valid_q      <= 1'b0;
         lo_q            <= '0;
         beat_pend_q     <= 1'b0;
         beat_q          <= '0;
         m_valid_q       <= 1'b0;
         m_data_q        <= '0;
         m_partial_q     <= 1'b0;
         beat_count_q    <= 16'h0000;
         err_underflow_q <= 1'b0;
      end else begin
         rd_pend_q       <= rd_pend_d;
         lo_valid_q      <= lo_valid_d;
         lo_q            <= lo_d;
         beat_pend_q     <= beat_pend_d;
         beat_q          <= beat_d;
         m_valid_q       <= m_valid_d;
         m_data_q        <= m_data_d;
         m_partial_q     <= m_partial_d;
         beat_count_q    <= beat_count_d;
         err_underflow_q <= err_underflow_d;
      end
   end

   assign m_valid       = m_valid_q;
   assign m_data        = m_data_q;
   assign m_partial     = m_partial_q;
   assign beat_count    = beat_count_q;
   assign err_underflow = err_underflow_q;

endmodule
`default_nettype wire

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 SHALL have parameter PAD_WORD, default 16'h0000, upper half of a partial (flushed) beat.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-005 SHALL have port fifo_data  input  16  FIFO read data, valid one cycle after an issued read.
REQ-006 SHALL have port fifo_underflow  input  1  FIFO underflow flag.
REQ-007 SHALL have port fifo_rd_en  output  1  FIFO read request.
REQ-008 SHALL have port flush  input  1  level; drain a lone buffered word as a padded beat.
REQ-009 SHALL have port m_valid  output  1  output beat valid.
REQ-010 SHALL have port m_ready  input  1  downstream accept.
REQ-011 SHALL have port m_data  output  32  packed beat, {second word, first word}.
REQ-012 SHALL have port m_partial  output  1  beat carries PAD_WORD in [31:16].
REQ-013 SHALL have port beat_count  output  16  accepted beats, wraps 16'hFFFF->0.
REQ-014 SHALL have port err_underflow  output  1  sticky, set when fifo_underflow seen.

Function
REQ-015 SHALL track rd_pend (read issued last cycle), lo_valid (first word held), beat_pend (full beat held awaiting output register).
REQ-016 SHALL define occ = 2*beat_pend + lo_valid + rd_pend; fifo_rd_en = !fifo_empty && occ < 2 && !rst, combinational.
REQ-017 SHALL never assert fifo_rd_en while fifo_empty=1.
REQ-018 SHALL, on rd_pend with lo_valid=0, capture fifo_data into lo register.
REQ-019 SHALL, on rd_pend with lo_valid=1, form {fifo_data, lo}; load m_data directly if output register free (m_valid=0 or m_ready=1), else hold it in beat_pend.
REQ-020 SHALL move a beat_pend beat to m_data in the first cycle output register is free; beat_pend priority over new combination (cannot coexist by REQ-016).
REQ-021 SHALL hold m_data, m_partial, m_valid stable while m_valid=1 and m_ready=0.
REQ-022 SHALL, when flush=1, lo_valid=1, rd_pend=0, beat_pend=0, fifo_empty=1 and output free, emit {PAD_WORD, lo} with m_partial=1 and clear lo_valid.
REQ-023 SHALL ignore flush when lo_valid=0 or any other REQ-022 condition is false.
REQ-024 SHALL increment beat_count on each m_valid && m_ready cycle, modulo 2^16.
REQ-025 SHALL set err_underflow on fifo_underflow=1; cleared only by rst.
REQ-026 SHALL sustain one beat per 3 cycles with fifo_empty=0 and m_ready=1.
REQ-027 SHALL expose state S_EMPTY (lo_valid=0, beat_pend=0), S_HALF (lo_valid=1), S_BEAT (beat_pend=1); S_EMPTY->S_HALF on first word; S_HALF->S_EMPTY on combine-to-output or flush; S_HALF->S_BEAT on combine with output blocked; S_BEAT->S_EMPTY on transfer.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, clear rd_pend, lo_valid, beat_pend, m_valid, m_partial, err_underflow to 0, m_data to 32'h0, beat_count to 16'h0, state to S_EMPTY.
REQ-029 SHALL drive fifo_rd_en=0 during rst; a word returned for a read issued before rst is discarded.

Structure
REQ-030 SHALL place WORD_W=16, BEAT_W=32 and the state enum in shared package fifo_pkg.
REQ-031 SHALL be flat; no sub-module.

Verification
REQ-032 SHALL test: FIFO holds 16'h1111,16'h2222, m_ready=1 -> one beat m_data=32'h2222_1111, m_partial=0, beat_count=1.
REQ-033 SHALL test: 6 words queued, m_ready=1 -> 3 beats spaced 3 cycles apart, fifo_rd_en never high with fifo_empty=1.
REQ-034 SHALL test: m_ready=0 for 10 cycles with 4 words queued -> m_valid=1, m_data stable, state S_BEAT, fifo_rd_en=0, exactly 4 words read.
REQ-035 SHALL test: single word 16'hABCD then flush=1 -> m_data=32'h0000_ABCD, m_partial=1.
REQ-036 SHALL test: rst asserted one cycle after fifo_rd_en -> all outputs at reset values next cycle, returned word discarded.
REQ-037 SHALL test: 65536 accepted beats -> beat_count wraps to 16'h0000; fifo_underflow pulse -> err_underflow stays 1 until rst.
